// File: rtl/cernbe_pkg.sv
// Shared types and constants for the CERN-BE register-bus initiator.
package cernbe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int TCNT_WIDTH      = 16;

endpackage

// File: rtl/cernbe_watchdog.sv
// Cycle counter for the Done wait; expired_o flags the last permitted wait cycle.
module cernbe_watchdog
  import cernbe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [15:0] count_q, count_d;

  // Expiry is combinational so the FSM can act in the same cycle the count reaches TIMEOUT-1.
  assign expired_o = enable_i && (count_q == 16'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cernbe_master.sv
// Register-bus initiator: turns a command stream into one-cycle VME strobes and returns
// a response with read data or a timeout error. One transfer outstanding at a time.
module cernbe_master
  import cernbe_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int TCNT_W     = TCNT_WIDTH
) (
  input  logic                  Clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-3:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-3:0] VMEAddr,
  output logic [DATA_WIDTH-1:0] VMEWrData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic [DATA_WIDTH-1:0] VMERdData,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone,
  output logic [TCNT_W-1:0]     timeout_count,
  output state_e                state_dbg
);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both 1; the
  // source holds its payload stable while valid is high and ready is low.

  state_e                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-3:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    rd_mem_q, rd_mem_d;
  logic                    wr_mem_q, wr_mem_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
  logic                    wd_clear, wd_enable, wd_expired;
  logic                    done_match;

  assign wd_clear   = (state_q != WAIT);
  assign wd_enable  = (state_q == WAIT);
  assign done_match = we_q ? VMEWrDone : VMERdDone;

  cernbe_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (Clk),
    .rst_ni   (rst_n),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rd_mem_d    = 1'b0;
    wr_mem_d    = 1'b0;
    tcnt_d      = tcnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = STROBE;
          req_ready_d = 1'b0;
          addr_d      = req_addr;
          wdata_d     = req_we ? req_wdata : '0;
          we_d        = req_we;
          rd_mem_d    = !req_we;
          wr_mem_d    = req_we;
        end
      end
      STROBE: state_d = WAIT;
      WAIT: begin
        // A matching Done on the expiry cycle still completes the transfer cleanly.
        if (done_match) begin
          rsp_rdata_d = we_q ? '0 : VMERdData;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wd_expired) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          tcnt_d      = (&tcnt_q) ? tcnt_q : tcnt_q + TCNT_W'(1);
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rd_mem_q    <= 1'b0;
      wr_mem_q    <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rd_mem_q    <= rd_mem_d;
      wr_mem_q    <= wr_mem_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign VMEAddr       = addr_q;
  assign VMEWrData     = wdata_q;
  assign VMERdMem      = rd_mem_q;
  assign VMEWrMem      = wr_mem_q;
  assign timeout_count = tcnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_cernbe_master.sv
// Bench for cernbe_master: main instance with TIMEOUT=8, plus a TIMEOUT=1 / 4-bit-counter
// instance used to reach timeout_count saturation quickly.
module tb_cernbe_master;
  import cernbe_pkg::*;

  localparam int TO = 8;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready, VMERdDone, VMEWrDone;
  logic [0:0]  req_addr;
  logic [31:0] req_wdata, VMERdData;
  logic        req_ready, rsp_valid, rsp_err, VMERdMem, VMEWrMem;
  logic [31:0] rsp_rdata, VMEWrData;
  logic [0:0]  VMEAddr;
  logic [15:0] timeout_count;
  state_e      state_dbg;

  logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_err, s_rd_mem, s_wr_mem;
  logic [0:0]  s_vme_addr;
  logic [31:0] s_rsp_rdata, s_vme_wdata;
  logic [3:0]  s_timeout_count;
  state_e      s_state_dbg;

  logic [32:0] exp_q[$];
  logic [15:0] exp_tcnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 Clk = ~Clk;

  cernbe_master #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .Clk(Clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(VMERdData), .VMERdDone(VMERdDone),
    .VMEWrDone(VMEWrDone), .timeout_count(timeout_count), .state_dbg(state_dbg)
  );

  cernbe_master #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT(1), .TCNT_W(4)) dut_sat (
    .Clk(Clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(1'b0),
    .req_addr(1'b0), .req_wdata(32'h0), .rsp_valid(s_rsp_valid), .rsp_ready(1'b1),
    .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err), .VMEAddr(s_vme_addr), .VMEWrData(s_vme_wdata),
    .VMERdMem(s_rd_mem), .VMEWrMem(s_wr_mem), .VMERdData(32'hDEADBEEF), .VMERdDone(1'b0),
    .VMEWrDone(1'b0), .timeout_count(s_timeout_count), .state_dbg(s_state_dbg)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    exp_tcnt = 16'h0;
    n_checks++;
    if ({state_dbg, req_ready, rsp_valid, rsp_err, VMERdMem, VMEWrMem} !== {IDLE, 5'b10000})
      $display("FAIL reset_ctrl got state=%0d rdy=%b vld=%b err=%b rd=%b wr=%b required IDLE,1,0,0,0,0",
               state_dbg, req_ready, rsp_valid, rsp_err, VMERdMem, VMEWrMem);
    else n_pass++;
    n_checks++;
    if ({rsp_rdata, VMEAddr, VMEWrData, timeout_count} !== '0)
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h tcnt=%h required all 0",
               rsp_rdata, VMEAddr, VMEWrData, timeout_count);
    else n_pass++;
  endtask

  // Read whose Done (if any) is driven done_at cycles after the accept cycle.
  task automatic run_read(input logic [0:0] addr, input int done_at, input bit wr_noise,
                          input logic [31:0] data, input string name);
    bit          timed_out;
    int          rsp_cyc, rd_pulses, strobe_cyc;
    bit          bad_ctrl, bad_hold;
    logic [32:0] exp;
    timed_out = !(done_at >= 2 && done_at <= TO + 1);
    rsp_cyc   = timed_out ? TO + 2 : done_at + 1;
    if (timed_out && exp_tcnt != 16'hFFFF) exp_tcnt++;
    exp_q.push_back(timed_out ? {1'b1, 32'h0} : {1'b0, data});
    rd_pulses = 0; strobe_cyc = -1; bad_ctrl = 0; bad_hold = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = $urandom; rsp_ready = 1'b1;
    for (int c = 1; c < rsp_cyc; c++) begin
      tick;
      req_valid = 1'b0;
      if (VMERdMem) begin rd_pulses++; strobe_cyc = c; end
      if (VMEWrMem || rsp_valid || req_ready) bad_ctrl = 1;
      if (VMEAddr !== addr || VMEWrData !== 32'h0) bad_hold = 1;
      VMERdDone = (c == done_at);
      VMERdData = (c == done_at) ? data : $urandom;
      VMEWrDone = wr_noise;
    end
    tick;
    VMERdDone = 1'b0; VMEWrDone = 1'b0;
    n_checks++;
    if (rd_pulses != 1 || strobe_cyc != 1)
      $display("FAIL %s_strobe got pulses=%0d at_cycle=%0d required 1 at 1", name, rd_pulses, strobe_cyc);
    else n_pass++;
    n_checks++;
    if (bad_ctrl || bad_hold)
      $display("FAIL %s_wait got ctrl_err=%b hold_err=%b required 0,0", name, bad_ctrl, bad_hold);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL %s_rsp_valid got %b at cycle %0d required 1", name, rsp_valid, rsp_cyc);
    end else begin
      n_pass++;
      exp = exp_q.pop_front();
      n_checks++;
      if ({rsp_err, rsp_rdata} !== exp)
        $display("FAIL %s_rsp got err=%b rdata=%h required err=%b rdata=%h",
                 name, rsp_err, rsp_rdata, exp[32], exp[31:0]);
      else n_pass++;
    end
    n_checks++;
    if (timeout_count !== exp_tcnt)
      $display("FAIL %s_tcnt got %h required %h", name, timeout_count, exp_tcnt);
    else n_pass++;
    tick;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || state_dbg !== IDLE)
      $display("FAIL %s_release got vld=%b rdy=%b state=%0d required 0,1,IDLE",
               name, rsp_valid, req_ready, state_dbg);
    else n_pass++;
  endtask

  task automatic test_read;
    run_read(1'b1, 2, 1'b0, 32'hCAFE0001, "read_basic");
  endtask

  task automatic test_write_backpressure;
    int          pulses, vld_cnt;
    bit          unstable, early;
    logic [32:0] exp;
    exp_q.push_back({1'b0, 32'h0});
    pulses = 0; vld_cnt = 0; unstable = 0; early = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 1'b0; req_wdata = 32'h12345678; rsp_ready = 1'b0;
    VMERdData = 32'hFFFF_FFFF;
    for (int c = 1; c <= 6; c++) begin
      tick;
      req_valid = 1'b0; req_wdata = $urandom;
      if (VMEWrMem) pulses++;
      if (VMERdMem || rsp_valid) early = 1;
      if (VMEWrData !== 32'h12345678 || VMEAddr !== 1'b0) unstable = 1;
      // Done in the strobe cycle and a read Done mid-wait must both be ignored.
      VMEWrDone = (c == 1) || (c == 6);
      VMERdDone = (c == 3);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      VMEWrDone = 1'b0; VMERdDone = 1'b0;
      if (rsp_valid) vld_cnt++;
      if (VMEWrData !== 32'h12345678 || VMEAddr !== 1'b0) unstable = 1;
      if (k == 0) begin
        exp = exp_q.pop_front();
        n_checks++;
        if ({rsp_err, rsp_rdata} !== exp)
          $display("FAIL write_rsp got err=%b rdata=%h required err=%b rdata=%h",
                   rsp_err, rsp_rdata, exp[32], exp[31:0]);
        else n_pass++;
      end else if (k == 3) begin
        n_checks++;
        if ({rsp_err, rsp_rdata} !== exp)
          $display("FAIL write_rsp_hold got err=%b rdata=%h required err=%b rdata=%h",
                   rsp_err, rsp_rdata, exp[32], exp[31:0]);
        else n_pass++;
      end
    end
    rsp_ready = 1'b1;
    tick;
    n_checks++;
    if (pulses != 1 || early)
      $display("FAIL write_strobe got pulses=%0d early=%b required 1,0", pulses, early);
    else n_pass++;
    n_checks++;
    if (vld_cnt != 4 || unstable)
      $display("FAIL write_hold got vld_cycles=%0d unstable=%b required 4,0", vld_cnt, unstable);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL write_release got vld=%b rdy=%b required 0,1", rsp_valid, req_ready);
    else n_pass++;
  endtask

  task automatic test_timeout;
    run_read(1'b1, 0, 1'b0, 32'h5555AAAA, "timeout");
    tick;
    VMERdDone = 1'b1; VMERdData = 32'h0BAD0BAD;
    tick;
    VMERdDone = 1'b0;
    tick;
    n_checks++;
    if (state_dbg !== IDLE || rsp_valid !== 1'b0 || req_ready !== 1'b1 || timeout_count !== exp_tcnt)
      $display("FAIL late_done got state=%0d vld=%b rdy=%b tcnt=%h required IDLE,0,1,%h",
               state_dbg, rsp_valid, req_ready, timeout_count, exp_tcnt);
    else n_pass++;
  endtask

  task automatic test_done_on_expiry;
    run_read(1'b0, TO + 1, 1'b0, 32'h600D0001, "done_on_expiry");
    run_read(1'b1, 1, 1'b0, 32'h11112222, "done_in_strobe");
  endtask

  task automatic test_wrong_done;
    run_read(1'b0, 0, 1'b1, 32'h33334444, "wrdone_on_read");
  endtask

  task automatic test_reset_mid;
    bit stray;
    stray = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 1'b1; rsp_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (2) tick;
    rst_n = 1'b0;
    tick;
    exp_tcnt = 16'h0;
    n_checks++;
    if (state_dbg !== IDLE || VMERdMem !== 1'b0 || VMEWrMem !== 1'b0 || req_ready !== 1'b1 ||
        rsp_valid !== 1'b0 || timeout_count !== 16'h0)
      $display("FAIL reset_mid got state=%0d rd=%b wr=%b rdy=%b vld=%b tcnt=%h required IDLE,0,0,1,0,0",
               state_dbg, VMERdMem, VMEWrMem, req_ready, rsp_valid, timeout_count);
    else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < TO + 4; c++) begin
      tick;
      if (rsp_valid) stray = 1;
    end
    n_checks++;
    if (stray || exp_q.size() != 0)
      $display("FAIL reset_mid_no_rsp got stray=%b pending=%0d required 0,0", stray, exp_q.size());
    else n_pass++;
    run_read(1'b0, 3, 1'b0, $urandom, "after_reset");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++)
      run_read(1'($urandom_range(0, 1)), $urandom_range(2, TO + 1), 1'($urandom_range(0, 1)),
               $urandom, "b2b");
  endtask

  task automatic test_saturation;
    int         n_rsp, bad;
    logic [3:0] exp_cnt;
    n_rsp = 0; bad = 0;
    s_req_valid = 1'b1;
    for (int c = 0; c < 200 && n_rsp < 20; c++) begin
      tick;
      if (s_rsp_valid) begin
        n_rsp++;
        exp_cnt = (n_rsp > 15) ? 4'hF : 4'(n_rsp);
        if (s_rsp_err !== 1'b1 || s_rsp_rdata !== 32'h0 || s_timeout_count !== exp_cnt) bad++;
      end
    end
    s_req_valid = 1'b0;
    n_checks++;
    if (n_rsp != 20) $display("FAIL sat_rsp_count got %0d required 20", n_rsp);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL sat_rsp_fields got %0d bad responses required 0", bad);
    else n_pass++;
    n_checks++;
    if (s_timeout_count !== 4'hF) $display("FAIL sat_final got %h required f", s_timeout_count);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 1'b0; req_wdata = 32'h0;
    rsp_ready = 1'b1; VMERdData = 32'h0; VMERdDone = 1'b0; VMEWrDone = 1'b0;
    s_req_valid = 1'b0; exp_tcnt = 16'h0;
    test_reset;
    test_read;
    test_write_backpressure;
    test_timeout;
    test_done_on_expiry;
    test_wrong_done;
    test_reset_mid;
    test_back_to_back;
    test_saturation;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached at %0t required completion earlier", $time);
    $fatal(1);
  end

endmodule
